// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: commands queued in a FIFO and issued one at a time as send_cmd strobes, with ack wait, timeout and gap.
// Optional retry-on-timeout is built only when UART_CMD_RETRY_EN is defined.
module uart_cmd_sequencer #(
  parameter int unsigned CMD_W       = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
`ifdef UART_CMD_RETRY_EN
  parameter int unsigned MAX_RETRY   = 2,
`endif
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   push,
  input  logic [CMD_W-1:0]       push_data,
  input  logic                   flush,
  input  logic                   en,
  input  logic                   cmd_sent,
  output logic [CMD_W-1:0]       cmd,
  output logic                   send_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   to_err,
  output logic [15:0]            sent_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_N = (GAP_CYC == 0) ? 1 : GAP_CYC;
  localparam int unsigned GAP_W = (GAP_N > 1) ? $clog2(GAP_N) : 1;
`ifdef UART_CMD_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t             state;
  logic [CMD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic               cmd_sent_q;
`ifdef UART_CMD_RETRY_EN
  logic [RTY_W-1:0]   retry_cnt;
`endif

  logic push_ok;
  logic pop;
  logic sent_edge;

  // full is taken from the registered count, so a push while full drops even if a pop happens too
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign push_ok   = push && !full && !flush;
  assign pop       = (state == IDLE) && en && !empty && !flush;
  assign sent_edge = cmd_sent && !cmd_sent_q;

  // FIFO storage (no reset needed on data)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, sequencer FSM and status registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      cmd_sent_q <= 1'b0;
      cmd        <= '0;
      send_cmd   <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      to_err     <= 1'b0;
      sent_cnt   <= '0;
`ifdef UART_CMD_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      cmd_sent_q <= cmd_sent;
      send_cmd   <= 1'b0;
      done       <= 1'b0;
      if (push && full && !flush) ovf <= 1'b1;

      if (flush) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_ok && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push_ok) count <= count - CNT_W'(1);

        case (state)
          IDLE: begin
            if (pop) begin
              cmd      <= mem[rd_ptr];
              send_cmd <= 1'b1;
              state    <= SEND;
`ifdef UART_CMD_RETRY_EN
              retry_cnt <= '0;
`endif
            end
          end
          SEND: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            // an ack edge wins over a simultaneous timeout
            if (sent_edge) begin
              sent_cnt <= sent_cnt + 16'd1;
              gap_cnt  <= '0;
              state    <= GAP;
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
`ifdef UART_CMD_RETRY_EN
              if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
                send_cmd  <= 1'b1;
                state     <= SEND;
              end else begin
                to_err  <= 1'b1;
                gap_cnt <= '0;
                state   <= GAP;
              end
`else
              to_err  <= 1'b1;
              gap_cnt <= '0;
              state   <= GAP;
`endif
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          GAP: begin
            if (gap_cnt == GAP_W'(GAP_N - 1)) begin
              done  <= empty;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed self-checking bench for uart_cmd_sequencer: one long-timeout instance and one with TIMEOUT_CYC=50.
// Honours UART_CMD_RETRY_EN for the expected timeout behaviour.
module tb_uart_cmd_sequencer;

  localparam int MAX_RETRY = 2;
  localparam int TO_B      = 50;
`ifdef UART_CMD_RETRY_EN
  localparam int EXP_PULSES = MAX_RETRY + 1;
`else
  localparam int EXP_PULSES = 1;
`endif

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  logic       a_push = 0, a_flush = 0, a_en = 0, a_cmd_sent = 0;
  logic [7:0] a_push_data = '0;
  logic [7:0] a_cmd;
  logic       a_send_cmd, a_full, a_empty, a_busy, a_done, a_ovf, a_to_err;
  logic [3:0] a_count;
  logic [15:0] a_sent_cnt;

  logic       b_push = 0, b_flush = 0, b_en = 0, b_cmd_sent = 0;
  logic [7:0] b_push_data = '0;
  logic [7:0] b_cmd;
  logic       b_send_cmd, b_full, b_empty, b_busy, b_done, b_ovf, b_to_err;
  logic [3:0] b_count;
  logic [15:0] b_sent_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  uart_cmd_sequencer #(.CMD_W(8), .DEPTH(8), .TIMEOUT_CYC(50000), .GAP_CYC(16)) dut_a (
    .clk(clk), .RST(RST), .push(a_push), .push_data(a_push_data), .flush(a_flush),
    .en(a_en), .cmd_sent(a_cmd_sent), .cmd(a_cmd), .send_cmd(a_send_cmd), .full(a_full),
    .empty(a_empty), .count(a_count), .busy(a_busy), .done(a_done), .ovf(a_ovf),
    .to_err(a_to_err), .sent_cnt(a_sent_cnt));

  uart_cmd_sequencer #(.CMD_W(8), .DEPTH(8), .TIMEOUT_CYC(TO_B), .GAP_CYC(16)) dut_b (
    .clk(clk), .RST(RST), .push(b_push), .push_data(b_push_data), .flush(b_flush),
    .en(b_en), .cmd_sent(b_cmd_sent), .cmd(b_cmd), .send_cmd(b_send_cmd), .full(b_full),
    .empty(b_empty), .count(b_count), .busy(b_busy), .done(b_done), .ovf(b_ovf),
    .to_err(b_to_err), .sent_cnt(b_sent_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [34:0] obs_a, obs_b, exp_v;
    #2;
    exp_v = {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    obs_a = {a_cmd, a_send_cmd, a_full, a_empty, a_count, a_busy, a_done, a_ovf, a_to_err, a_sent_cnt};
    obs_b = {b_cmd, b_send_cmd, b_full, b_empty, b_count, b_busy, b_done, b_ovf, b_to_err, b_sent_cnt};
    n_cmp++;
    if (obs_a !== exp_v) begin n_bad++; $display("FAIL reset_a: got %h want %h", obs_a, exp_v); end
    n_cmp++;
    if (obs_b !== exp_v) begin n_bad++; $display("FAIL reset_b: got %h want %h", obs_b, exp_v); end
    @(negedge clk);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    int pulses = 0, dones = 0, resp = -1;
    int pc0 = 0, pc1 = 0;
    logic [7:0] c0 = '0, c1 = '0;
    a_push = 1; a_push_data = 8'h06; tick();
    a_push_data = 8'h0A; tick();
    a_push = 0; a_en = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (a_send_cmd) begin
        if (pulses == 0) begin pc0 = cyc; c0 = a_cmd; end
        if (pulses == 1) begin pc1 = cyc; c1 = a_cmd; end
        pulses++;
        resp = cyc + 100;
      end
      if (a_done) dones++;
      if (cyc == resp) a_cmd_sent = 1;
      if (cyc == resp + 4) a_cmd_sent = 0;
    end
    a_en = 0;
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL normal_pulses: got %0d want 2", pulses); end
    n_cmp++;
    if (c0 !== 8'h06) begin n_bad++; $display("FAIL normal_cmd0: got %h want 06", c0); end
    n_cmp++;
    if (c1 !== 8'h0A) begin n_bad++; $display("FAIL normal_cmd1: got %h want 0a", c1); end
    n_cmp++;
    if (pc1 - pc0 !== 118) begin n_bad++; $display("FAIL normal_spacing: got %0d want 118", pc1 - pc0); end
    n_cmp++;
    if (a_sent_cnt !== 16'd2) begin n_bad++; $display("FAIL normal_sent_cnt: got %0d want 2", a_sent_cnt); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL normal_done: got %0d want 1", dones); end
    n_cmp++;
    if ({a_busy, a_empty, a_to_err} !== 3'b010) begin
      n_bad++; $display("FAIL normal_idle: got busy/empty/to_err %b want 010", {a_busy, a_empty, a_to_err});
    end
  endtask

  task automatic test_overflow();
    int pulses = 0, resp = -1;
    logic [7:0] got [8];
    for (int i = 1; i <= 9; i++) begin
      a_push = 1; a_push_data = 8'(i);
      tick();
      if (i == 8) begin
        n_cmp++;
        if ({a_full, a_count, a_ovf} !== {1'b1, 4'd8, 1'b0}) begin
          n_bad++; $display("FAIL ovf_full8: got full/count/ovf %b/%0d/%b want 1/8/0", a_full, a_count, a_ovf);
        end
      end
    end
    a_push = 0;
    n_cmp++;
    if ({a_count, a_ovf} !== {4'd8, 1'b1}) begin
      n_bad++; $display("FAIL ovf_drop: got count/ovf %0d/%b want 8/1", a_count, a_ovf);
    end
    a_en = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (a_send_cmd) begin
        if (pulses < 8) got[pulses] = a_cmd;
        pulses++;
        resp = cyc + 5;
      end
      if (cyc == resp) a_cmd_sent = 1;
      if (cyc == resp + 2) a_cmd_sent = 0;
    end
    a_en = 0;
    n_cmp++;
    if (pulses !== 8) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 8", pulses); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, got[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    for (int i = 0; i < 4; i++) begin
      a_push = 1; a_push_data = 8'hA1 + 8'(i); tick();
    end
    a_push = 0; a_en = 1;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      tick();
      if (a_send_cmd) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL flush_pulse: got no send_cmd want one within 50 cycles"); end
    repeat (3) tick();
    n_cmp++;
    if ({a_busy, a_count} !== {1'b1, 4'd3}) begin
      n_bad++; $display("FAIL flush_pre: got busy/count %b/%0d want 1/3", a_busy, a_count);
    end
    a_flush = 1; tick(); a_flush = 0;
    n_cmp++;
    if ({a_busy, a_empty, a_count, a_send_cmd} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL flush_clear: got busy/empty/count/send %b/%b/%0d/%b want 0/1/0/0",
                        a_busy, a_empty, a_count, a_send_cmd);
    end
    a_cmd_sent = 1; repeat (3) tick();
    a_cmd_sent = 0; repeat (2) tick();
    a_en = 0;
    n_cmp++;
    if ({a_sent_cnt, a_busy} !== {16'd10, 1'b0}) begin
      n_bad++; $display("FAIL flush_sent_cnt: got %0d busy %b want 10 busy 0", a_sent_cnt, a_busy);
    end
  endtask

  task automatic test_corner();
    bit seen = 0;
    b_push = 1; b_push_data = 8'h44; tick();
    b_push = 0; b_en = 1;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      tick();
      if (b_send_cmd) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL corner_pulse: got no send_cmd want one within 20 cycles"); end
    repeat (TO_B) tick();
    b_cmd_sent = 1;
    tick();
    n_cmp++;
    if ({b_sent_cnt, b_to_err} !== {16'd1, 1'b0}) begin
      n_bad++; $display("FAIL corner_edge: got sent_cnt/to_err %0d/%b want 1/0", b_sent_cnt, b_to_err);
    end
    repeat (2) tick();
    b_cmd_sent = 0;
    repeat (30) tick();
    b_en = 0;
    n_cmp++;
    if ({b_busy, b_to_err} !== 2'b00) begin
      n_bad++; $display("FAIL corner_idle: got busy/to_err %b want 00", {b_busy, b_to_err});
    end
  endtask

  task automatic test_timeout();
    int pulses = 0, p0 = -1, terr = -1, badcmd = 0;
    b_push = 1; b_push_data = 8'h55; tick();
    b_push = 0; b_en = 1;
    for (int cyc = 0; cyc < 260; cyc++) begin
      tick();
      if (b_send_cmd) begin
        if (p0 < 0) p0 = cyc;
        if (b_cmd !== 8'h55) badcmd++;
        pulses++;
      end
      if (b_to_err && terr < 0) terr = cyc;
    end
    b_en = 0;
    n_cmp++;
    if (pulses !== EXP_PULSES) begin n_bad++; $display("FAIL timeout_pulses: got %0d want %0d", pulses, EXP_PULSES); end
    n_cmp++;
    if (badcmd !== 0) begin n_bad++; $display("FAIL timeout_cmd: got %0d wrong cmd strobes want 0", badcmd); end
    n_cmp++;
    if (terr - p0 !== EXP_PULSES * (TO_B + 1)) begin
      n_bad++; $display("FAIL timeout_delay: got %0d want %0d", terr - p0, EXP_PULSES * (TO_B + 1));
    end
    n_cmp++;
    if ({b_to_err, b_busy, b_sent_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      n_bad++; $display("FAIL timeout_end: got to_err/busy/sent_cnt %b/%b/%0d want 1/0/1", b_to_err, b_busy, b_sent_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    logic [34:0] obs, exp_v;
    a_push = 1; a_push_data = 8'h77; tick();
    a_push_data = 8'h78; tick();
    a_push = 0; a_en = 1;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      tick();
      if (a_send_cmd) seen = 1;
    end
    repeat (5) tick();
    #3;
    RST = 1'b1;
    #1;
    exp_v = {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    obs = {a_cmd, a_send_cmd, a_full, a_empty, a_count, a_busy, a_done, a_ovf, a_to_err, a_sent_cnt};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_mid_a: got %h want %h", obs, exp_v); end
    n_cmp++;
    if ({b_to_err, b_sent_cnt} !== 17'd0) begin
      n_bad++; $display("FAIL reset_mid_b: got to_err/sent_cnt %b/%0d want 0/0", b_to_err, b_sent_cnt);
    end
    a_en = 0;
    @(negedge clk);
    RST = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_flush();
    test_corner();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
